// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcodes, FSM states,
// status bit positions, operand masking and flag-update masks.
package alu_seq_pkg;

  localparam int WORD_W = 20;
  localparam int HALF_W = 10;
  localparam int TAG_W  = 4;

  localparam logic [4:0] OP_TRAP = 5'd0;
  localparam logic [4:0] OP_NOP  = 5'd1;
  localparam logic [4:0] OP_JMP  = 5'd2;
  localparam logic [4:0] OP_JZ   = 5'd3;
  localparam logic [4:0] OP_JS   = 5'd4;
  localparam logic [4:0] OP_JZS  = 5'd5;
  localparam logic [4:0] OP_LSR  = 5'd6;
  localparam logic [4:0] OP_XSR  = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_XOR  = 5'd11;
  localparam logic [4:0] OP_SHR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_ROL  = 5'd15;
  localparam logic [4:0] OP_SWP  = 5'd16;
  localparam logic [4:0] OP_INC  = 5'd17;
  localparam logic [4:0] OP_DEC  = 5'd18;
  localparam logic [4:0] OP_ADD  = 5'd19;
  localparam logic [4:0] OP_ADC  = 5'd20;
  localparam logic [4:0] OP_SUB  = 5'd21;
  localparam logic [4:0] OP_SBC  = 5'd22;
  localparam logic [4:0] OP_EQ   = 5'd23;
  localparam logic [4:0] OP_GT   = 5'd24;
  localparam logic [4:0] OP_LT   = 5'd25;
  localparam logic [4:0] OP_GE   = 5'd26;
  localparam logic [4:0] OP_LE   = 5'd27;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_WB2,
    S_BR,
    S_TRAP
  } state_t;

  localparam int ST_Z = 0;
  localparam int ST_S = 1;
  localparam int ST_C = 2;

  // Half-word mode keeps only the low HALF_W bits.
  function automatic logic [WORD_W-1:0] half_mask(
    input logic [WORD_W-1:0] v,
    input logic              mode
  );
    logic [WORD_W-1:0] m;
    m = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};
    return mode ? v : (v & m);
  endfunction

  // Which status bits ({C,S,Z}) an opcode is allowed to write.
  function automatic logic [2:0] flag_mask(
    input logic [4:0] op
  );
    logic [2:0] m;
    m = 3'b000;
    unique case (1'b1)
      (op >= OP_NOT && op <= OP_XOR): m = 3'b011;
      (op == OP_SHR || op == OP_SHL): m = 3'b111;
      (op >= OP_INC && op <= OP_SBC): m = 3'b111;
      (op >= OP_EQ && op <= OP_LE):   m = 3'b011;
      (op == OP_LSR || op == OP_XSR): m = 3'b111;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Result masking and next-status computation for the sequencer.
// In: op, mode, a, raw ALU results/flags, status. Out: masked results, status_next.
module alu_seq_flags
  import alu_seq_pkg::*;
(
  input  logic [4:0]        op,
  input  logic              mode,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] result,
  input  logic [WORD_W-1:0] result_b,
  input  logic              zero,
  input  logic              sign,
  input  logic              carry,
  input  logic [2:0]        status,
  output logic [WORD_W-1:0] res,
  output logic [WORD_W-1:0] res_b,
  output logic [2:0]        status_next
);

  logic       z;
  logic       s;
  logic [2:0] cand;
  logic [2:0] m;

  always_comb begin
    res   = half_mask(result, mode);
    res_b = half_mask(result_b, mode);
    z     = (res == '0);
    s     = mode ? res[WORD_W-1] : res[HALF_W-1];
    m     = flag_mask(op);
    cand  = {carry, s, z};
    unique case (1'b1)
      (op == OP_LSR): cand = a[2:0];
      (op == OP_XSR): cand = status ^ a[2:0];
      (op >= OP_EQ && op <= OP_LE):
        cand = {status[ST_C], sign, zero};
      default: cand = {carry, s, z};
    endcase
    // Only bits the opcode owns are replaced.
    status_next = (cand & m) | (status & ~m);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue ALU sequencer: accepts one op, drives the ALU,
// writes back via valid/ready, resolves branches, owns {C,S,Z}.
// Ports: req_* in, alu_* to/from ALU, wb_*, br_*, status, trap.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic              req_mode,
  input  logic [WORD_W-1:0] req_a,
  input  logic [WORD_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_dst,
  input  logic [TAG_W-1:0]  req_dst_b,
  output logic [4:0]        alu_op,
  output logic              alu_mode,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] alu_result_b,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_carry,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [TAG_W-1:0]  wb_dst,
  output logic [WORD_W-1:0] wb_data,
  output logic              br_valid,
  output logic              br_taken,
  output logic [WORD_W-1:0] br_target,
  output logic [2:0]        status,
  output logic              trap,
  input  logic              trap_clr
);

  state_t            state;
  logic [4:0]        op_q;
  logic              mode_q;
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;
  logic [TAG_W-1:0]  dst_q;
  logic [TAG_W-1:0]  dst_b_q;
  logic [WORD_W-1:0] res_b_q;

  logic [WORD_W-1:0] res;
  logic [WORD_W-1:0] res_b;
  logic [2:0]        status_next;
  logic              taken;

  assign req_ready = (state == S_IDLE);
  assign alu_op    = op_q;
  assign alu_mode  = mode_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_cin   = status[ST_C];

  alu_seq_flags u_flags (
    .op          (op_q),
    .mode        (mode_q),
    .a           (a_q),
    .result      (alu_result),
    .result_b    (alu_result_b),
    .zero        (alu_zero),
    .sign        (alu_sign),
    .carry       (alu_carry),
    .status      (status),
    .res         (res),
    .res_b       (res_b),
    .status_next (status_next)
  );

  always_comb begin
    taken = 1'b0;
    unique case (op_q)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = status[ST_Z];
      OP_JS:   taken = status[ST_S];
      OP_JZS:  taken = status[ST_Z] | status[ST_S];
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      mode_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      dst_q     <= '0;
      dst_b_q   <= '0;
      res_b_q   <= '0;
      wb_valid  <= 1'b0;
      wb_dst    <= '0;
      wb_data   <= '0;
      br_valid  <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= '0;
      status    <= 3'b000;
      trap      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            mode_q  <= req_mode;
            a_q     <= half_mask(req_a, req_mode);
            b_q     <= half_mask(req_b, req_mode);
            dst_q   <= req_dst;
            dst_b_q <= req_dst_b;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          status <= status_next;
          unique case (1'b1)
            (op_q >= OP_NOT && op_q <= OP_SBC): begin
              wb_valid <= 1'b1;
              wb_dst   <= dst_q;
              wb_data  <= res;
              res_b_q  <= res_b;
              state    <= S_WB;
            end
            (op_q >= OP_JMP && op_q <= OP_JZS): begin
              br_valid  <= 1'b1;
              br_taken  <= taken;
              br_target <= a_q;
              state     <= S_BR;
            end
            (op_q == OP_NOP || op_q == OP_LSR ||
             op_q == OP_XSR ||
             (op_q >= OP_EQ && op_q <= OP_LE)): begin
              state <= S_IDLE;
            end
            default: begin
              trap  <= 1'b1;
              state <= S_TRAP;
            end
          endcase
        end
        S_WB: begin
          if (wb_ready) begin
            if (op_q == OP_SWP) begin
              wb_dst  <= dst_b_q;
              wb_data <= res_b_q;
              state   <= S_WB2;
            end else begin
              wb_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_WB2: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_BR: begin
          br_valid <= 1'b0;
          br_taken <= 1'b0;
          state    <= S_IDLE;
        end
        S_TRAP: begin
          if (trap_clr) begin
            trap  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
